// File: rtl/board_ram_arbiter.sv
// Arbiter for the single port of one battleship board RAM: video has absolute
// priority, then the board-clear sequencer, then game-logic read/write requests.
module board_ram_arbiter #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 2,
   parameter int CLEAR_CELLS = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vid_on,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [DATA_W-1:0] vid_data,
   input  logic              game_req,
   input  logic              game_we,
   input  logic [ADDR_W-1:0] game_addr,
   input  logic [DATA_W-1:0] game_wdata,
   output logic              game_ack,
   output logic [DATA_W-1:0] game_rdata,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_GAME} owner_t;
   typedef enum logic [1:0] {SLOT_IDLE, SLOT_VID, SLOT_CLEAR, SLOT_GAME} slot_t;

   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CLEAR_CELLS - 1);

   slot_t             slot;
   owner_t            own1;
   owner_t            own2;
   logic              outstanding;
   logic [ADDR_W-1:0] clear_cnt;

   // Who gets the port at the coming edge
   always_comb begin
      slot = SLOT_IDLE;
      if (vid_on)
         slot = SLOT_VID;
      else if (clear_busy)
         slot = SLOT_CLEAR;
      else if (game_req && !outstanding && !game_ack)
         slot = SLOT_GAME;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_wdata <= '0;
         own1      <= OWN_NONE;
      end else begin
         ram_we <= 1'b0;
         own1   <= OWN_NONE;
         unique case (slot)
            SLOT_VID: begin
               ram_addr <= vid_addr;
               own1     <= OWN_VID;
            end
            SLOT_CLEAR: begin
               ram_addr  <= clear_cnt;
               ram_we    <= 1'b1;
               ram_wdata <= '0;
            end
            SLOT_GAME: begin
               ram_addr  <= game_addr;
               ram_we    <= game_we;
               ram_wdata <= game_wdata;
               own1      <= game_we ? OWN_NONE : OWN_GAME;
            end
            default: ;
         endcase
      end
   end

   // A new clear_start always restarts from cell 0, even mid-clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clear_busy <= 1'b0;
         clear_cnt  <= '0;
      end else if (clear_start) begin
         clear_busy <= 1'b1;
         clear_cnt  <= '0;
      end else if (slot == SLOT_CLEAR) begin
         if (clear_cnt == LAST_CELL)
            clear_busy <= 1'b0;
         else
            clear_cnt <= clear_cnt + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         own2        <= OWN_NONE;
         vid_data    <= '0;
         game_rdata  <= '0;
         game_ack    <= 1'b0;
         outstanding <= 1'b0;
      end else begin
         own2     <= own1;
         game_ack <= 1'b0;
         if (own2 == OWN_VID)
            vid_data <= ram_rdata;
         if (slot == SLOT_GAME && game_we) begin
            game_ack <= 1'b1;
         end else if (own2 == OWN_GAME) begin
            game_ack   <= 1'b1;
            game_rdata <= ram_rdata;
         end
         // Outstanding spans issue up to the edge where the ack pulse ends
         if (slot == SLOT_GAME)
            outstanding <= 1'b1;
         else if (game_ack)
            outstanding <= 1'b0;
      end
   end

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Bench for board_ram_arbiter: a behavioural board RAM plus a shadow board
// that records what every cell should hold.
module tb_board_ram_arbiter;

   localparam int ADDR_W      = 10;
   localparam int DATA_W      = 2;
   localparam int CLEAR_CELLS = 256;
   localparam int DEPTH       = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              vid_on;
   logic [ADDR_W-1:0] vid_addr;
   logic [DATA_W-1:0] vid_data;
   logic              game_req;
   logic              game_we;
   logic [ADDR_W-1:0] game_addr;
   logic [DATA_W-1:0] game_wdata;
   logic              game_ack;
   logic [DATA_W-1:0] game_rdata;
   logic              clear_start;
   logic              clear_busy;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   logic [DATA_W-1:0] mem      [DEPTH];
   logic [DATA_W-1:0] init_mem [DEPTH];
   logic [DATA_W-1:0] board    [DEPTH];
   logic              load_all = 1'b0;
   int unsigned       wr_addr_q [$];
   int unsigned       wr_data_q [$];

   int compared   = 0;
   int mismatched = 0;

   board_ram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_CELLS(CLEAR_CELLS)
   ) dut (
      .clk(clk), .rst(rst),
      .vid_on(vid_on), .vid_addr(vid_addr), .vid_data(vid_data),
      .game_req(game_req), .game_we(game_we), .game_addr(game_addr),
      .game_wdata(game_wdata), .game_ack(game_ack), .game_rdata(game_rdata),
      .clear_start(clear_start), .clear_busy(clear_busy),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM; every committed write is logged in order
   always @(posedge clk) begin
      if (load_all) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= init_mem[i];
      end else if (ram_we === 1'b1) begin
         mem[ram_addr] <= ram_wdata;
         wr_addr_q.push_back(32'(ram_addr));
         wr_data_q.push_back(32'(ram_wdata));
      end
      ram_rdata <= mem[ram_addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v_on, input logic [ADDR_W-1:0] v_addr,
                                input logic req, input logic we,
                                input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                                input logic cstart);
      vid_on      = v_on;
      vid_addr    = v_addr;
      game_req    = req;
      game_we     = we;
      game_addr   = addr;
      game_wdata  = wdata;
      clear_start = cstart;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkReset(input string phase);
      checkOutput({phase, "_vid_data"}, 32'(vid_data), 0);
      checkOutput({phase, "_game_ack"}, 32'(game_ack), 0);
      checkOutput({phase, "_game_rdata"}, 32'(game_rdata), 0);
      checkOutput({phase, "_clear_busy"}, 32'(clear_busy), 0);
      checkOutput({phase, "_ram_addr"}, 32'(ram_addr), 0);
      checkOutput({phase, "_ram_we"}, 32'(ram_we), 0);
      checkOutput({phase, "_ram_wdata"}, 32'(ram_wdata), 0);
   endtask

   // One full requester handshake; expected latency assumes the port stays free
   task automatic gameAccess(input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata, input int exp_lat, input string tag);
      int lat = 0;
      bit got = 1'b0;
      game_req   = 1'b1;
      game_we    = we;
      game_addr  = addr;
      game_wdata = wdata;
      while (!got && lat < 200) begin
         tick();
         lat++;
         if (game_ack === 1'b1) got = 1'b1;
      end
      checkOutput({tag, "_acked"}, 32'(got), 1);
      checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      if (got && !we) checkOutput({tag, "_rdata"}, 32'(game_rdata), 32'(board[addr]));
      if (got && we) board[addr] = wdata;
      game_req = 1'b0;
      tick();
      checkOutput({tag, "_ack_pulse"}, 32'(game_ack), 0);
   endtask

   initial begin
      logic [ADDR_W-1:0] va [34];
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] wd;
      logic [DATA_W-1:0] exp_vid;
      logic              rwe;
      int                issues;
      int                cyc;
      int                bad;
      bit                acked;
      bit                found;

      rst = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < DEPTH; i++)
         init_mem[i] = DATA_W'($urandom_range(0, 3));
      init_mem[0] = 2'd3;
      init_mem[1] = 2'd1;
      init_mem[2] = 2'd2;
      init_mem[10'h010] = 2'd3;
      init_mem[10'h023] = 2'd0;
      for (int i = 0; i < DEPTH; i++)
         board[i] = init_mem[i];
      @(negedge clk);
      load_all = 1'b1;
      @(negedge clk);
      load_all = 1'b0;
      checkReset("reset");
      rst = 1'b0;
      tick();

      // Video owns the port: pixel data follows addresses by two edges
      va[0] = 10'd0;
      va[1] = 10'd1;
      va[2] = 10'd2;
      for (int i = 3; i < 34; i++)
         va[i] = ADDR_W'($urandom_range(0, DEPTH - 1));
      for (int i = 0; i < 34; i++) begin
         applyStimulus(1'b1, va[i], 1'b0, 1'b0, '0, '0, 1'b0);
         tick();
         checkOutput("vid_ram_we", 32'(ram_we), 0);
         if (i >= 2) checkOutput("vid_data", 32'(vid_data), 32'(board[va[i-2]]));
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      tick();
      tick();
      exp_vid = board[va[33]];
      checkOutput("vid_data_tail", 32'(vid_data), 32'(exp_vid));
      tick();
      checkOutput("vid_data_hold", 32'(vid_data), 32'(exp_vid));

      // Directed game write in blanking
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 10'h023, 2'd2, 1'b0);
      tick();
      checkOutput("gw_ram_we", 32'(ram_we), 1);
      checkOutput("gw_ram_addr", 32'(ram_addr), 32'h023);
      checkOutput("gw_ram_wdata", 32'(ram_wdata), 2);
      checkOutput("gw_ack", 32'(game_ack), 1);
      board[10'h023] = 2'd2;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      tick();
      checkOutput("gw_ack_drop", 32'(game_ack), 0);
      checkOutput("gw_ram_we_drop", 32'(ram_we), 0);

      // Random game traffic with the port free
      for (int i = 0; i < 16; i++) begin
         rwe = 1'($urandom_range(0, 1));
         ra  = ADDR_W'($urandom_range(10'h040, 10'h0FF));
         wd  = DATA_W'($urandom_range(0, 3));
         gameAccess(rwe, ra, wd, rwe ? 1 : 3, "rand");
      end
      gameAccess(1'b0, 10'h023, '0, 3, "rd023");

      // Game read in flight while video grabs the port
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 10'h023, '0, 1'b0);
      tick();
      checkOutput("col_ram_addr", 32'(ram_addr), 32'h023);
      checkOutput("col_ack_n", 32'(game_ack), 0);
      applyStimulus(1'b1, 10'h010, 1'b1, 1'b0, 10'h023, '0, 1'b0);
      tick();
      checkOutput("col_ack_n1", 32'(game_ack), 0);
      checkOutput("col_vid_hold1", 32'(vid_data), 32'(exp_vid));
      applyStimulus(1'b0, 10'h010, 1'b1, 1'b0, 10'h023, '0, 1'b0);
      tick();
      checkOutput("col_ack_n2", 32'(game_ack), 1);
      checkOutput("col_rdata", 32'(game_rdata), 32'(board[10'h023]));
      checkOutput("col_vid_hold2", 32'(vid_data), 32'(exp_vid));
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      tick();
      checkOutput("col_vid_data", 32'(vid_data), 32'(board[10'h010]));
      checkOutput("col_ack_end", 32'(game_ack), 0);

      // Game write starved by video, then issued on the first blank edge
      wd = DATA_W'($urandom_range(0, 3));
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 10'h010, 1'b1, 1'b1, 10'h050, wd, 1'b0);
         tick();
         checkOutput("blk_ack", 32'(game_ack), 0);
         checkOutput("blk_ram_we", 32'(ram_we), 0);
         if (i >= 2) checkOutput("blk_vid_data", 32'(vid_data), 32'(board[10'h010]));
      end
      applyStimulus(1'b0, 10'h010, 1'b1, 1'b1, 10'h050, wd, 1'b0);
      tick();
      checkOutput("blk_issue_we", 32'(ram_we), 1);
      checkOutput("blk_issue_addr", 32'(ram_addr), 32'h050);
      checkOutput("blk_issue_wdata", 32'(ram_wdata), 32'(wd));
      checkOutput("blk_issue_ack", 32'(game_ack), 1);
      board[10'h050] = wd;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      tick();
      gameAccess(1'b0, 10'h050, '0, 3, "rd050");

      // Clear a board full of SHIP with video cutting in 8 on / 8 off
      for (int i = 0; i < CLEAR_CELLS; i++)
         board[i] = 2'd3;
      for (int i = 0; i < DEPTH; i++)
         init_mem[i] = board[i];
      load_all = 1'b1;
      tick();
      load_all = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();
      applyStimulus(1'b0, 10'h300, 1'b0, 1'b0, '0, '0, 1'b1);
      tick();
      checkOutput("clr_busy_start", 32'(clear_busy), 1);
      issues = 0;
      cyc    = 0;
      acked  = 1'b0;
      while (!acked && cyc < 2000) begin
         applyStimulus((cyc % 16) < 8, 10'h300, 1'b1, 1'b0, 10'h0A0, '0, 1'b0);
         tick();
         if (ram_we === 1'b1) issues++;
         if ((cyc % 16) < 8) checkOutput("clr_pause", 32'(ram_we), 0);
         checkOutput("clr_busy", 32'(issues < CLEAR_CELLS), 32'(clear_busy));
         if (game_ack === 1'b1) begin
            acked = 1'b1;
            checkOutput("clr_game_after", 32'(issues), 32'(CLEAR_CELLS));
            checkOutput("clr_game_rdata", 32'(game_rdata), 0);
         end
         cyc++;
      end
      checkOutput("clr_game_acked", 32'(acked), 1);
      for (int i = 0; i < CLEAR_CELLS; i++)
         board[i] = 2'd0;
      applyStimulus(1'b0, 10'h300, 1'b0, 1'b0, '0, '0, 1'b0);
      tick();
      checkOutput("clr_ack_drop", 32'(game_ack), 0);
      checkOutput("clr_wr_count", 32'(wr_addr_q.size()), 32'(CLEAR_CELLS));
      bad = 0;
      for (int i = 0; i < wr_addr_q.size(); i++)
         if (wr_addr_q[i] != 32'(i) || wr_data_q[i] != 0) bad++;
      checkOutput("clr_wr_order", 32'(bad), 0);
      checkOutput("clr_vid_data", 32'(vid_data), 32'(board[10'h300]));

      // Reset arriving partway through a clear
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      found = 1'b0;
      cyc   = 0;
      while (!found && cyc < 400) begin
         tick();
         if (ram_we === 1'b1 && ram_addr === 10'd100) found = 1'b1;
         cyc++;
      end
      checkOutput("rst_reach100", 32'(found), 1);
      rst = 1'b1;
      #1;
      checkReset("midclear");
      wr_addr_q.delete();
      wr_data_q.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++)
         tick();
      checkOutput("rst_busy_after", 32'(clear_busy), 0);
      checkOutput("rst_no_writes", 32'(wr_addr_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
